alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Round-robin arbiter and sequencer that shares the single 8-bit ALU between two requesters, e.g. the main decode path and a secondary unit.
- Latches one requester's operation and drives the ALU select and operand lines.
- Captures the combinational ALU result one cycle later.
- Returns the result to the owning requester with a one-cycle valid pulse.
- Sits between the requesters and the ALU (FORWARD/ADD/AND/OR units). The ALU itself is not modified.

## Interface
Parameters:
- WIDTH, 8, operand/result width (signed, two's complement)
- SEL_W, 3, ALU select width

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- req0, req1  input  1  operation request from requester 0 / 1
- op0, op1  input  SEL_W  ALU select: 000 FORWARD (result = data2), 001 ADD, 010 AND, 011 OR; 1xx reserved
- a0, a1  input  WIDTH  data1 operand per requester
- b0, b1  input  WIDTH  data2 operand per requester
- gnt0, gnt1  output  1  one-cycle pulse: operands accepted
- alu_data1, alu_data2  output  WIDTH  operands driven to the shared ALU (registered)
- alu_select  output  SEL_W  select driven to the shared ALU (registered)
- alu_result  input  WIDTH  combinational ALU output
- rsp_valid0, rsp_valid1  output  1  one-cycle pulse: rsp_data is valid for that requester
- rsp_data  output  WIDTH  captured result, held until next capture
- busy  output  1  high in BUSY state

## Operation
States: IDLE, BUSY, DONE.
- IDLE: sample req0/req1 at the edge.
  - None asserted: stay in IDLE.
  - Otherwise: pick a winner, latch its op/a/b into alu_select/alu_data1/alu_data2, record owner, pulse gnt of the winner, go to BUSY.
- BUSY: at the edge, register rsp_data, pulse rsp_valid of the owner, go to DONE.
  - Supported op: rsp_data <= alu_result.
  - Reserved op (1xx): rsp_data <= 0.
- DONE: same arbitration as IDLE, so back-to-back issue is possible. If no request, go to IDLE.
- Arbitration:
  - Only one requester asserted: it wins.
  - Both asserted: the requester not granted last wins.
  - The last-granted flag updates on every grant.
- req is sampled only in IDLE and DONE; it is ignored in BUSY.
- A requester still holding req at the DONE edge is treated as issuing a new operation with its current op/a/b.
- Arithmetic: ADD is WIDTH-bit two's-complement wrap-around; there is no overflow flag. The arbiter never alters operand values.
- alu_select/alu_data1/alu_data2 and rsp_data hold their last values between operations.

## Timing
- Reset (RESET high at an edge):
  - state = IDLE; last-granted = 1, so requester 0 wins the first contention.
  - gnt0/gnt1/rsp_valid0/rsp_valid1/busy = 0.
  - alu_data1/alu_data2/rsp_data = 0; alu_select = 000.
- Reset during BUSY or DONE: the in-flight operation is discarded and no rsp_valid is emitted.
- Request sampled at edge N:
  - gnt high during cycle N→N+1.
  - ALU inputs are stable from edge N.
  - rsp_valid high during cycle N+1→N+2.
- Latency: 2 edges from acceptance to result. Sustained throughput: one operation per 2 cycles.
- gnt and rsp_valid are each exactly one cycle wide. gnt0 and gnt1 are never high together; rsp_valid0 and rsp_valid1 are never high together.
- ALU combinational delay must settle within one clock period; alu_result is sampled only at the BUSY edge.
- rsp_valid of one operation coincides with gnt of the next when issued from DONE.

## Test plan
- Reset: hold RESET 2 cycles with req0=req1=1 → all outputs 0, no gnt; release → first grant goes to requester 0.
- Single OR: req0, op0=011, a0=25, b0=3 → gnt0 at N, alu_select=011, rsp_valid0 at N+1, rsp_data=8'b00011011.
- Signed operands: req1, OR, a1=2, b1=-5 → rsp_data=8'b11111011. Then AND, a1=6, b1=-2 → rsp_data=8'b00000110.
- Contention and round-robin: req0 and req1 held high; req0 ADD 25+3, req1 FORWARD b1=-128 →
  - grants alternate gnt0, gnt1, gnt0…
  - responses 28 and 8'b10000000 alternate on rsp_valid0/rsp_valid1, one every 2 cycles.
- Boundaries:
  - ADD 127+1 → rsp_data=8'b10000000 (wrap).
  - Reserved op 101 → rsp_data=0 with normal rsp_valid.
- Mid-operation reset: assert RESET on the BUSY edge → no rsp_valid0, state IDLE, rsp_data=0. A new request afterwards completes normally.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two
// requesters. An operation is latched onto the ALU lines on grant. The ALU
// result is captured one edge later and returned with a one-cycle valid pulse.
module alu_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             req0,
  input  logic             req1,
  input  logic [SEL_W-1:0] op0,
  input  logic [SEL_W-1:0] op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  output logic [SEL_W-1:0] alu_select,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;

  // Per-requester views so the grant mux and pulse logic are index-driven.
  logic [1:0]       req_vec;
  logic [SEL_W-1:0] op_vec [2];
  logic [WIDTH-1:0] a_vec  [2];
  logic [WIDTH-1:0] b_vec  [2];

  logic [1:0]       gnt_reg, gnt_next;
  logic [1:0]       rsp_valid_reg, rsp_valid_next;
  logic             last_reg;   // requester granted most recently
  logic             owner_reg;  // requester owning the in-flight operation
  logic [SEL_W-1:0] alu_select_reg;
  logic [WIDTH-1:0] alu_data1_reg, alu_data2_reg, rsp_data_reg;

  logic             issue;      // accept an operation at this edge
  logic             capture;    // capture the ALU result at this edge
  logic             winner;
  logic             reserved_op;

  assign req_vec = {req1, req0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign op_vec[gi]         = (gi == 0) ? op0 : op1;
      assign a_vec[gi]          = (gi == 0) ? a0  : a1;
      assign b_vec[gi]          = (gi == 0) ? b0  : b1;
      assign gnt_next[gi]       = issue && (winner == 1'(gi));
      assign rsp_valid_next[gi] = capture && (owner_reg == 1'(gi));
    end
  endgenerate

  // Selects with the top bit set have no ALU unit behind them.
  assign reserved_op = alu_select_reg[SEL_W-1];

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state plus issue/capture strobes; contention goes to the requester not served last.
  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    capture    = 1'b0;
    winner     = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (|req_vec) begin
          issue      = 1'b1;
          winner     = (&req_vec) ? ~last_reg : req_vec[1];
          state_next = BUSY;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        capture    = 1'b1;
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch the winner's operation on issue and the ALU result on capture.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      gnt_reg        <= '0;
      rsp_valid_reg  <= '0;
      last_reg       <= 1'b1;
      owner_reg      <= 1'b0;
      alu_select_reg <= '0;
      alu_data1_reg  <= '0;
      alu_data2_reg  <= '0;
      rsp_data_reg   <= '0;
    end else begin
      gnt_reg       <= gnt_next;
      rsp_valid_reg <= rsp_valid_next;
      if (issue) begin
        alu_select_reg <= op_vec[winner];
        alu_data1_reg  <= a_vec[winner];
        alu_data2_reg  <= b_vec[winner];
        owner_reg      <= winner;
        last_reg       <= winner;
      end
      if (capture) begin
        rsp_data_reg <= reserved_op ? '0 : alu_result;
      end
    end
  end

  assign gnt0       = gnt_reg[0];
  assign gnt1       = gnt_reg[1];
  assign rsp_valid0 = rsp_valid_reg[0];
  assign rsp_valid1 = rsp_valid_reg[1];
  assign alu_select = alu_select_reg;
  assign alu_data1  = alu_data1_reg;
  assign alu_data2  = alu_data2_reg;
  assign rsp_data   = rsp_data_reg;
  assign busy       = (state_reg == BUSY);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed steps from the test plan followed
// by random traffic, checked every cycle against a transaction-level model.
module tb_alu_share_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       req0, req1;
  logic [2:0] op0, op1;
  logic [7:0] a0, a1, b0, b1;
  logic       gnt0, gnt1;
  logic [7:0] alu_data1, alu_data2;
  logic [2:0] alu_select;
  logic [7:0] alu_result;
  logic       rsp_valid0, rsp_valid1;
  logic [7:0] rsp_data;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  alu_share_arbiter #(.WIDTH(8), .SEL_W(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_select(alu_select),
    .alu_result(alu_result),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_data(rsp_data), .busy(busy)
  );

  // Stand-in for the shared ALU; reserved selects give junk the arbiter must mask.
  always_comb begin
    case (alu_select)
      3'b000:  alu_result = alu_data2;
      3'b001:  alu_result = alu_data1 + alu_data2;
      3'b010:  alu_result = alu_data1 & alu_data2;
      3'b011:  alu_result = alu_data1 | alu_data2;
      default: alu_result = 8'hA5;
    endcase
  end

  // Reference model state: one operation at a time, result due one edge after grant.
  logic       m_inflight, m_owner, m_last;
  logic [7:0] m_pending;
  logic       e_g0, e_g1, e_v0, e_v1, e_busy;
  logic [2:0] e_sel;
  logic [7:0] e_d1, e_d2, e_rsp;

  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int sum;
    case (op)
      3'd0: return b;
      3'd1: begin
        sum = (int'(a) + int'(b)) % 256;
        return sum[7:0];
      end
      3'd2: return a & b;
      3'd3: return a | b;
      default: return 8'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic model_edge(input logic rst,
                            input logic r0, input logic [2:0] o0, input logic [7:0] x0, input logic [7:0] y0,
                            input logic r1, input logic [2:0] o1, input logic [7:0] x1, input logic [7:0] y1);
    logic w;
    if (rst) begin
      m_inflight = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_pending = 8'd0;
      e_g0 = 0; e_g1 = 0; e_v0 = 0; e_v1 = 0;
      e_sel = 3'd0; e_d1 = 8'd0; e_d2 = 8'd0; e_rsp = 8'd0;
    end else begin
      e_g0 = 0; e_g1 = 0; e_v0 = 0; e_v1 = 0;
      if (m_inflight) begin
        if (m_owner) e_v1 = 1; else e_v0 = 1;
        e_rsp      = m_pending;
        m_inflight = 1'b0;
      end else if (r0 || r1) begin
        w = (r0 && r1) ? !m_last : r1;
        if (w) begin
          e_g1 = 1; e_sel = o1; e_d1 = x1; e_d2 = y1;
        end else begin
          e_g0 = 1; e_sel = o0; e_d1 = x0; e_d2 = y0;
        end
        m_pending  = ref_op(e_sel, e_d1, e_d2);
        m_owner    = w;
        m_last     = w;
        m_inflight = 1'b1;
      end
    end
    e_busy = m_inflight;
  endtask

  // One clock: drive inputs, advance the model, clock, then compare on the falling edge.
  task automatic cyc(input logic rst,
                     input logic r0, input logic [2:0] o0, input logic [7:0] x0, input logic [7:0] y0,
                     input logic r1, input logic [2:0] o1, input logic [7:0] x1, input logic [7:0] y1);
    RESET = rst;
    req0 = r0; op0 = o0; a0 = x0; b0 = y0;
    req1 = r1; op1 = o1; a1 = x1; b1 = y1;
    model_edge(rst, r0, o0, x0, y0, r1, o1, x1, y1);
    @(posedge CLK);
    @(negedge CLK);
    check("gnt0", 32'(gnt0), 32'(e_g0));
    check("gnt1", 32'(gnt1), 32'(e_g1));
    check("rsp_valid0", 32'(rsp_valid0), 32'(e_v0));
    check("rsp_valid1", 32'(rsp_valid1), 32'(e_v1));
    check("busy", 32'(busy), 32'(e_busy));
    check("alu_select", 32'(alu_select), 32'(e_sel));
    check("alu_data1", 32'(alu_data1), 32'(e_d1));
    check("alu_data2", 32'(alu_data2), 32'(e_d2));
    check("rsp_data", 32'(rsp_data), 32'(e_rsp));
    if (gnt0 || gnt1)
      $display("[%0t] issue  owner=%0d sel=%0d d1=%0h d2=%0h", $time, gnt1, alu_select, alu_data1, alu_data2);
    if (rsp_valid0 || rsp_valid1)
      $display("[%0t] result owner=%0d data=%0h", $time, rsp_valid1, rsp_data);
  endtask

  task automatic idle();
    cyc(0, 0, 3'd0, 8'd0, 8'd0, 0, 3'd0, 8'd0, 8'd0);
  endtask

  initial begin
    @(negedge CLK);

    // Reset held two cycles with both requests high: nothing granted.
    cyc(1, 1, 3'd1, 8'd25, 8'd3, 1, 3'd0, 8'd0, 8'h80);
    cyc(1, 1, 3'd1, 8'd25, 8'd3, 1, 3'd0, 8'd0, 8'h80);
    check("reset_gnt0", 32'(gnt0), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    // Release: requester 0 wins the first contention.
    cyc(0, 1, 3'd1, 8'd25, 8'd3, 1, 3'd0, 8'd0, 8'h80);
    check("first_grant_req0", 32'({gnt1, gnt0}), 32'b01);
    idle();
    idle();

    // Single OR 25|3 = 27.
    cyc(0, 1, 3'b011, 8'd25, 8'd3, 0, 3'd0, 8'd0, 8'd0);
    check("or_select", 32'(alu_select), 32'b011);
    idle();
    check("or_result", 32'(rsp_data), 32'h1B);
    idle();

    // Signed operands on requester 1.
    cyc(0, 0, 3'd0, 8'd0, 8'd0, 1, 3'b011, 8'd2, 8'hFB);
    idle();
    check("or_signed", 32'(rsp_data), 32'hFB);
    cyc(0, 0, 3'd0, 8'd0, 8'd0, 1, 3'b010, 8'd6, 8'hFE);
    idle();
    check("and_signed", 32'(rsp_data), 32'h06);
    idle();

    // Contention held high: alternating grants, back-to-back from DONE.
    for (int i = 0; i < 8; i++)
      cyc(0, 1, 3'b001, 8'd25, 8'd3, 1, 3'b000, 8'd0, 8'h80);
    idle();
    idle();

    // Wrap-around add.
    cyc(0, 1, 3'b001, 8'd127, 8'd1, 0, 3'd0, 8'd0, 8'd0);
    idle();
    check("add_wrap", 32'(rsp_data), 32'h80);
    // Reserved select returns zero with a normal valid pulse.
    cyc(0, 0, 3'd0, 8'd0, 8'd0, 1, 3'b101, 8'd9, 8'd9);
    idle();
    check("reserved_valid", 32'(rsp_valid1), 32'd1);
    check("reserved_zero", 32'(rsp_data), 32'd0);
    idle();

    // Reset on the BUSY edge discards the operation.
    cyc(0, 1, 3'b001, 8'd5, 8'd6, 0, 3'd0, 8'd0, 8'd0);
    cyc(1, 0, 3'd0, 8'd0, 8'd0, 0, 3'd0, 8'd0, 8'd0);
    check("midrst_no_valid", 32'(rsp_valid0), 32'd0);
    check("midrst_data", 32'(rsp_data), 32'd0);
    cyc(0, 1, 3'b011, 8'h40, 8'h02, 0, 3'd0, 8'd0, 8'd0);
    idle();
    check("after_rst_result", 32'(rsp_data), 32'h42);
    idle();

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0),
          ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
          ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
